// File: rtl/chan_mux_if.sv
// rtl/chan_mux_if.sv - channel-side and output-side stream signals of chan_mux
interface chan_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/chan_mux.sv
// rtl/chan_mux.sv - packet-granular N:1 stream mux with fixed or round-robin channel select
// Round-robin arbitration and its pointer exist only when CHAN_MUX_RR_EN is defined.
module chan_mux #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SW-1:0]       sel,
  chan_mux_if.slave           bus,
  output logic [CHANNELS-1:0] grant,
  output logic                busy
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state;
  logic                run_q;
  logic [WIDTH-1:0]    out_data_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [CHANNELS-1:0] rdy;
  logic                acc;
  logic [WIDTH-1:0]    gdata;
  logic                glast;
  logic                sel_ok;
  logic                pick_ok;
  logic [SW-1:0]       pick_idx;
  logic [CHANNELS-1:0] pick_oh;

  // The deasserted reset is retimed through one flop before state may advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign rdy           = grant & {CHANNELS{~out_valid_q | bus.out_ready}};
  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state == LOCKED);
  assign acc           = |(bus.in_valid & rdy);
  assign sel_ok        = ({1'b0, sel} < (SW+1)'(CHANNELS));

  always_comb begin
    gdata = '0;
    glast = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant[k]) begin
        gdata = bus.in_data[k*WIDTH +: WIDTH];
        glast = bus.in_last[k];
      end
    end
  end

`ifdef CHAN_MUX_RR_EN
  logic [SW-1:0] ptr;
  logic [SW-1:0] cand;
  logic [SW-1:0] rr_idx;
  logic          rr_found;

  // Search starts just after the last round-robin winner and wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr;
    cand     = ptr;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = SW'((int'(ptr) + i) % CHANNELS);
      if (!rr_found && bus.in_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    pick_idx = sel;
    pick_ok  = sel_ok && bus.in_valid[sel];
`ifdef CHAN_MUX_RR_EN
    if (mode) begin
      pick_idx = rr_idx;
      pick_ok  = rr_found;
    end
`endif
    pick_oh = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pick_oh[k] = (pick_idx == SW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef CHAN_MUX_RR_EN
      ptr         <= SW'(CHANNELS - 1);
`endif
    end else if (run_q) begin
      if (acc) begin
        out_data_q  <= gdata;
        out_last_q  <= glast;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant <= pick_oh;
            state <= LOCKED;
`ifdef CHAN_MUX_RR_EN
            if (mode) ptr <= pick_idx;
`endif
          end
        end
        LOCKED: begin
          if (acc && glast) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/chan_mux.md
CHAN_MUX -- requirements
Module: chan_mux

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16); SW = clog2(CHANNELS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-006 sel  input  SW  channel index used in fixed mode.
REQ-007 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel valid.
REQ-009 in_last  input  CHANNELS  per-channel end-of-packet marker.
REQ-010 in_ready  output  CHANNELS  per-channel ready; at most one bit high.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_last  output  1  registered end-of-packet marker.
REQ-014 out_ready  input  1  downstream ready.
REQ-015 grant  output  CHANNELS  one-hot locked channel, all-zero in IDLE.
REQ-016 busy  output  1  high in LOCKED.

Function
REQ-017 FSM states: IDLE, LOCKED.
REQ-018 IDLE, fixed mode: when sel < CHANNELS and in_valid[sel]=1, grant <= one-hot(sel), go LOCKED next cycle.
REQ-019 IDLE, round-robin: candidate = first k with in_valid[k]=1, searching ptr+1, ptr+2, ... modulo CHANNELS; grant it, ptr <= k, go LOCKED.
REQ-020 IDLE, no eligible channel, or sel >= CHANNELS in fixed mode: stay IDLE, grant = 0.
REQ-021 mode and sel are sampled only in IDLE; changes in LOCKED are ignored until return to IDLE.
REQ-022 in_ready[g] = (out_valid==0 || out_ready==1) for granted channel g in LOCKED; all other in_ready bits 0; all bits 0 in IDLE.
REQ-023 Beat accepted when in_valid[g] && in_ready[g]; out_data/out_last load that beat and out_valid <= 1 next edge (latency 1 cycle).
REQ-024 out_valid cleared when out_ready=1 and no new beat accepted that cycle; accept and drain in the same cycle keeps out_valid=1 with new data (full throughput, 1 beat/cycle).
REQ-025 out_data/out_last stable while out_valid=1 && out_ready=0.
REQ-026 Accepted beat with in_last[g]=1: LOCKED -> IDLE next edge, grant cleared; earliest next grant one cycle later (1 bubble per packet).
REQ-027 Packets never interleave; a granted channel keeps the output until its last beat, regardless of other valids.
REQ-028 Fixed mode does not update ptr.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, grant 0, busy 0, out_valid 0, out_last 0, out_data 0, in_ready 0, ptr = CHANNELS-1 (channel 0 wins first round-robin).
REQ-030 Reset mid-packet discards the partial packet and the held output beat; no recovery of lost beats.
REQ-031 Reset release is synchronised in-block; first state update on second rising edge after rst_n rises.

Configuration
REQ-032 Macro CHAN_MUX_RR_EN: defined -> round-robin logic and ptr present, mode behaves per REQ-005/019.
REQ-033 Undefined -> no ptr, no round-robin logic; mode input ignored, block always operates in fixed mode.

Verification (WIDTH=8, CHANNELS=4, CHAN_MUX_RR_EN defined unless noted)
REQ-034 Fixed mode, sel=2, ch2 sends 0x11,0x22,0x33(last), out_ready=1 -> out beats 0x11,0x22,0x33, out_last on third, grant=0100 then 0000, one bubble.
REQ-035 Round-robin after reset, ch0,ch1,ch3 all valid with 2-beat packets -> grant order 0001,0010,1000,0001; no interleaving.
REQ-036 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data held, in_ready[g]=0 once out_valid=1, no beat lost or duplicated.
REQ-037 Change sel 1->3 while LOCKED on ch1 -> packet completes on ch1; next grant to ch3.
REQ-038 rst_n low on beat 2 of 4 -> out_valid=0, grant=0, busy=0 immediately; after release, round-robin restarts at ch0.
REQ-039 CHAN_MUX_RR_EN undefined, mode=1, sel=1, ch0 and ch1 valid -> ch1 granted, ch0 never granted.
